// File: rtl/mem_arbiter_if.sv
// Bundle of CPU-side request/response ports and unified-memory command ports
// shared by the arbiter (slave view) and the CPU/memory side (master view).
interface mem_arbiter_if;
    logic        inst_req;
    logic [31:0] inst_adr;
    logic [31:0] inst;
    logic        inst_ready;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] data_adr;
    logic [31:0] data_out;
    logic [31:0] data_in;
    logic        data_ready;
    logic [31:0] m_adr;
    logic [31:0] m_wdata;
    logic        m_rd;
    logic        m_wr;
    logic [31:0] m_rdata;

    modport slave (
        input  inst_req, inst_adr, mem_read, mem_write, data_adr, data_out, m_rdata,
        output inst, inst_ready, data_in, data_ready, m_adr, m_wdata, m_rd, m_wr
    );

    modport master (
        output inst_req, inst_adr, mem_read, mem_write, data_adr, data_out, m_rdata,
        input  inst, inst_ready, data_in, data_ready, m_adr, m_wdata, m_rd, m_wr
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data ports onto one fixed-latency memory,
// data-first with alternation under contention.
//
// state | meaning
// IDLE  | sample requests, grant and load command registers
// ACC_D | data access in progress, command held LATENCY cycles
// ACC_I | fetch access in progress, always a read
// DONE  | one-cycle ready pulse, requests ignored, strobes low
module mem_arbiter #(
    parameter int unsigned LATENCY = 2
) (
    input  logic          i_clk,
    input  logic          i_rst,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACC_D, ACC_I, DONE} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);
    localparam logic       GRANT_I  = 1'b0;
    localparam logic       GRANT_D  = 1'b1;

    state_t      r_state;
    logic        r_last;
    logic [3:0]  r_cnt;
    logic [31:0] r_inst;
    logic [31:0] r_data_in;
    logic        r_inst_ready;
    logic        r_data_ready;
    logic [31:0] r_m_adr;
    logic [31:0] r_m_wdata;
    logic        r_m_rd;
    logic        r_m_wr;

    logic w_data_req;
    logic w_any_req;
    logic w_pick_d;

    assign w_data_req = bus.mem_read | bus.mem_write;
    assign w_any_req  = w_data_req | bus.inst_req;
    // Data wins unless both are waiting and data had the previous grant.
    assign w_pick_d   = w_data_req & (~bus.inst_req | (r_last == GRANT_I));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_last       <= GRANT_I;
            r_cnt        <= 4'd0;
            r_inst       <= 32'd0;
            r_data_in    <= 32'd0;
            r_inst_ready <= 1'b0;
            r_data_ready <= 1'b0;
            r_m_adr      <= 32'd0;
            r_m_wdata    <= 32'd0;
            r_m_rd       <= 1'b0;
            r_m_wr       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_cnt  <= CNT_LOAD;
                        r_last <= w_pick_d ? GRANT_D : GRANT_I;
                        if (w_pick_d) begin
                            r_m_adr   <= bus.data_adr;
                            r_m_wdata <= bus.data_out;
                            r_m_wr    <= bus.mem_write;
                            r_m_rd    <= ~bus.mem_write;
                            r_state   <= ACC_D;
                        end else begin
                            r_m_adr   <= bus.inst_adr;
                            r_m_wr    <= 1'b0;
                            r_m_rd    <= 1'b1;
                            r_state   <= ACC_I;
                        end
                    end
                end
                ACC_D, ACC_I: begin
                    if (r_cnt == 4'd0) begin
                        r_m_rd  <= 1'b0;
                        r_m_wr  <= 1'b0;
                        r_state <= DONE;
                        if (r_state == ACC_I) begin
                            r_inst       <= bus.m_rdata;
                            r_inst_ready <= 1'b1;
                        end else begin
                            // A write completes without disturbing the last read word.
                            if (!r_m_wr) begin
                                r_data_in <= bus.m_rdata;
                            end
                            r_data_ready <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                DONE: begin
                    r_inst_ready <= 1'b0;
                    r_data_ready <= 1'b0;
                    r_state      <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.inst       = r_inst;
    assign bus.data_in    = r_data_in;
    assign bus.inst_ready = r_inst_ready;
    assign bus.data_ready = r_data_ready;
    assign bus.m_adr      = r_m_adr;
    assign bus.m_wdata    = r_m_wdata;
    assign bus.m_rd       = r_m_rd;
    assign bus.m_wr       = r_m_wr;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with LATENCY 2, 1 and 4 instances sharing
// one behavioural memory; cycle k is sampled on the falling edge after the k-th rise.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mem_arbiter_if if2();
    mem_arbiter_if if1();
    mem_arbiter_if if4();

    mem_arbiter #(.LATENCY(2)) dut2 (.i_clk(clk), .i_rst(rst), .bus(if2.slave));
    mem_arbiter #(.LATENCY(1)) dut1 (.i_clk(clk), .i_rst(rst), .bus(if1.slave));
    mem_arbiter #(.LATENCY(4)) dut4 (.i_clk(clk), .i_rst(rst), .bus(if4.slave));

    logic [31:0] mem [0:63];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'(i) * 32'h0101_0101;
            mem[4]  <= 32'h0050_0093;
            mem[16] <= 32'h1111_2222;
            mem[32] <= 32'hAAAA_0001;
            mem[48] <= 32'hBBBB_0002;
        end else if (if2.m_wr) begin
            mem[if2.m_adr[7:2]] <= if2.m_wdata;
        end
    end

    assign if2.m_rdata = mem[if2.m_adr[7:2]];
    assign if1.m_rdata = mem[if1.m_adr[7:2]];
    assign if4.m_rdata = mem[if4.m_adr[7:2]];

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        if2.inst_req = 0; if2.inst_adr = 0; if2.mem_read = 0; if2.mem_write = 0; if2.data_adr = 0; if2.data_out = 0;
        if1.inst_req = 0; if1.inst_adr = 0; if1.mem_read = 0; if1.mem_write = 0; if1.data_adr = 0; if1.data_out = 0;
        if4.inst_req = 0; if4.inst_adr = 0; if4.mem_read = 0; if4.mem_write = 0; if4.data_adr = 0; if4.data_out = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int k = 0; k < 2; k++) begin
            checks++; if (if2.inst !== 32'd0) begin errors++; $display("FAIL reset_inst got=%h exp=0", if2.inst); end
            checks++; if (if2.data_in !== 32'd0) begin errors++; $display("FAIL reset_data_in got=%h exp=0", if2.data_in); end
            checks++; if ({if2.inst_ready, if2.data_ready, if2.m_rd, if2.m_wr} !== 4'b0) begin errors++; $display("FAIL reset_strobes got=%b exp=0000", {if2.inst_ready, if2.data_ready, if2.m_rd, if2.m_wr}); end
            checks++; if ({if2.m_adr, if2.m_wdata} !== 64'd0) begin errors++; $display("FAIL reset_cmd got=%h exp=0", {if2.m_adr, if2.m_wdata}); end
            tick();
        end
    endtask

    task automatic test_fetch();
        do_reset();
        if2.inst_req = 1; if2.inst_adr = 32'h10;
        for (int k = 1; k <= 5; k++) begin
            tick();
            checks++; if (if2.m_rd !== (k >= 1 && k <= 2)) begin errors++; $display("FAIL fetch_m_rd k=%0d got=%b", k, if2.m_rd); end
            checks++; if (if2.inst_ready !== (k == 3)) begin errors++; $display("FAIL fetch_ready k=%0d got=%b", k, if2.inst_ready); end
            checks++; if (if2.m_wr !== 1'b0) begin errors++; $display("FAIL fetch_m_wr k=%0d got=%b exp=0", k, if2.m_wr); end
            if (k <= 2) begin
                checks++; if (if2.m_adr !== 32'h10) begin errors++; $display("FAIL fetch_adr k=%0d got=%h exp=10", k, if2.m_adr); end
            end
            if (k == 3) begin
                checks++; if (if2.inst !== 32'h0050_0093) begin errors++; $display("FAIL fetch_inst got=%h exp=00500093", if2.inst); end
                if2.inst_req = 0;
            end
        end
    endtask

    task automatic test_contention();
        do_reset();
        if2.inst_req = 1; if2.inst_adr = 32'h10;
        if2.mem_read = 1; if2.data_adr = 32'h40;
        for (int k = 1; k <= 9; k++) begin
            tick();
            checks++; if (if2.m_rd !== (k == 1 || k == 2 || k == 5 || k == 6)) begin errors++; $display("FAIL cont_m_rd k=%0d got=%b", k, if2.m_rd); end
            checks++; if (if2.data_ready !== (k == 3)) begin errors++; $display("FAIL cont_data_ready k=%0d got=%b", k, if2.data_ready); end
            checks++; if (if2.inst_ready !== (k == 7)) begin errors++; $display("FAIL cont_inst_ready k=%0d got=%b", k, if2.inst_ready); end
            if (k == 1) begin
                checks++; if (if2.m_adr !== 32'h40) begin errors++; $display("FAIL cont_first_adr got=%h exp=40", if2.m_adr); end
            end
            if (k == 5) begin
                checks++; if (if2.m_adr !== 32'h10) begin errors++; $display("FAIL cont_second_adr got=%h exp=10", if2.m_adr); end
            end
            if (k == 3) begin
                checks++; if (if2.data_in !== 32'h1111_2222) begin errors++; $display("FAIL cont_data_in got=%h exp=11112222", if2.data_in); end
                if2.mem_read = 0;
            end
            if (k == 7) begin
                checks++; if (if2.inst !== 32'h0050_0093) begin errors++; $display("FAIL cont_inst got=%h exp=00500093", if2.inst); end
                if2.inst_req = 0;
            end
        end
    endtask

    task automatic test_alternation();
        do_reset();
        if2.inst_req = 1; if2.inst_adr = 32'h80;
        if2.mem_read = 1; if2.data_adr = 32'hC0;
        for (int k = 1; k <= 16; k++) begin
            if (k == 16) begin
                if2.inst_req = 0; if2.mem_read = 0;
            end
            tick();
            checks++; if (if2.data_ready !== (k == 3 || k == 11)) begin errors++; $display("FAIL alt_data_ready k=%0d got=%b", k, if2.data_ready); end
            checks++; if (if2.inst_ready !== (k == 7 || k == 15)) begin errors++; $display("FAIL alt_inst_ready k=%0d got=%b", k, if2.inst_ready); end
            checks++; if ((if2.m_rd & if2.m_wr) !== 1'b0) begin errors++; $display("FAIL alt_rd_wr_excl k=%0d got=1 exp=0", k); end
            if (k == 1 || k == 2 || k == 9 || k == 10) begin
                checks++; if (if2.m_adr !== 32'hC0) begin errors++; $display("FAIL alt_d_adr k=%0d got=%h exp=c0", k, if2.m_adr); end
            end
            if (k == 5 || k == 6 || k == 13 || k == 14) begin
                checks++; if (if2.m_adr !== 32'h80) begin errors++; $display("FAIL alt_i_adr k=%0d got=%h exp=80", k, if2.m_adr); end
            end
            if (k == 3) begin
                checks++; if (if2.data_in !== 32'hBBBB_0002) begin errors++; $display("FAIL alt_data_in got=%h exp=bbbb0002", if2.data_in); end
            end
            if (k == 7) begin
                checks++; if (if2.inst !== 32'hAAAA_0001) begin errors++; $display("FAIL alt_inst got=%h exp=aaaa0001", if2.inst); end
            end
        end
        for (int k = 17; k <= 20; k++) begin
            tick();
            checks++; if ({if2.m_rd, if2.m_wr, if2.inst_ready, if2.data_ready} !== 4'b0) begin errors++; $display("FAIL alt_quiet k=%0d got=%b exp=0000", k, {if2.m_rd, if2.m_wr, if2.inst_ready, if2.data_ready}); end
        end
    endtask

    task automatic test_write();
        do_reset();
        if2.mem_read = 1; if2.data_adr = 32'h40;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 3) begin
                checks++; if (if2.data_in !== 32'h1111_2222) begin errors++; $display("FAIL wr_pre_read got=%h exp=11112222", if2.data_in); end
                if2.mem_read = 0;
            end
        end
        if2.mem_read = 1; if2.mem_write = 1; if2.data_adr = 32'h20; if2.data_out = 32'hDEAD_BEEF;
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++; if (if2.m_wr !== (k <= 2)) begin errors++; $display("FAIL wr_m_wr k=%0d got=%b", k, if2.m_wr); end
            checks++; if (if2.m_rd !== 1'b0) begin errors++; $display("FAIL wr_m_rd k=%0d got=%b exp=0", k, if2.m_rd); end
            checks++; if (if2.data_ready !== (k == 3)) begin errors++; $display("FAIL wr_ready k=%0d got=%b", k, if2.data_ready); end
            if (k <= 2) begin
                checks++; if ({if2.m_adr, if2.m_wdata} !== {32'h20, 32'hDEAD_BEEF}) begin errors++; $display("FAIL wr_cmd k=%0d got=%h", k, {if2.m_adr, if2.m_wdata}); end
            end
            if (k == 3) begin
                checks++; if (if2.data_in !== 32'h1111_2222) begin errors++; $display("FAIL wr_data_in_kept got=%h exp=11112222", if2.data_in); end
                if2.mem_read = 0; if2.mem_write = 0;
            end
        end
        if2.mem_read = 1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++; if (if2.data_ready !== (k == 3)) begin errors++; $display("FAIL wr_readback_ready k=%0d got=%b", k, if2.data_ready); end
            if (k == 3) begin
                checks++; if (if2.data_in !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_readback got=%h exp=deadbeef", if2.data_in); end
                if2.mem_read = 0;
            end
        end
    endtask

    task automatic test_drop();
        int pulses = 0;
        do_reset();
        if2.inst_req = 1; if2.inst_adr = 32'h10;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 1) if2.inst_req = 0;
            if (if2.inst_ready) pulses++;
            checks++; if (if2.m_rd !== (k <= 2)) begin errors++; $display("FAIL drop_m_rd k=%0d got=%b", k, if2.m_rd); end
            checks++; if (if2.inst_ready !== (k == 3)) begin errors++; $display("FAIL drop_ready k=%0d got=%b", k, if2.inst_ready); end
        end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL drop_pulse_count got=%0d exp=1", pulses); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        if2.mem_read = 1; if2.data_adr = 32'h40;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 3) if2.mem_read = 0;
        end
        checks++; if (if2.data_in !== 32'h1111_2222) begin errors++; $display("FAIL rmid_pre got=%h exp=11112222", if2.data_in); end
        if2.mem_read = 1;
        tick();
        checks++; if (if2.m_rd !== 1'b1) begin errors++; $display("FAIL rmid_in_access got=%b exp=1", if2.m_rd); end
        rst = 1'b1;
        tick();
        rst = 1'b0; if2.mem_read = 0;
        checks++; if ({if2.m_rd, if2.m_wr, if2.data_ready} !== 3'b0) begin errors++; $display("FAIL rmid_strobes got=%b exp=000", {if2.m_rd, if2.m_wr, if2.data_ready}); end
        checks++; if (if2.data_in !== 32'd0) begin errors++; $display("FAIL rmid_data_in got=%h exp=0", if2.data_in); end
        for (int k = 3; k <= 6; k++) begin
            tick();
            checks++; if ({if2.m_rd, if2.data_ready} !== 2'b0) begin errors++; $display("FAIL rmid_quiet k=%0d got=%b exp=00", k, {if2.m_rd, if2.data_ready}); end
        end
        if2.inst_req = 1; if2.inst_adr = 32'h10;
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++; if (if2.inst_ready !== (k == 3)) begin errors++; $display("FAIL rmid_resume_ready k=%0d got=%b", k, if2.inst_ready); end
            if (k == 3) begin
                checks++; if (if2.inst !== 32'h0050_0093) begin errors++; $display("FAIL rmid_resume_inst got=%h exp=00500093", if2.inst); end
                if2.inst_req = 0;
            end
        end
    endtask

    task automatic test_latency();
        do_reset();
        if1.inst_req = 1; if1.inst_adr = 32'h10;
        if4.inst_req = 1; if4.inst_adr = 32'h10;
        for (int k = 1; k <= 7; k++) begin
            tick();
            checks++; if (if1.m_rd !== (k == 1)) begin errors++; $display("FAIL lat1_fetch_rd k=%0d got=%b", k, if1.m_rd); end
            checks++; if (if1.inst_ready !== (k == 2)) begin errors++; $display("FAIL lat1_fetch_ready k=%0d got=%b", k, if1.inst_ready); end
            checks++; if (if4.m_rd !== (k <= 4)) begin errors++; $display("FAIL lat4_fetch_rd k=%0d got=%b", k, if4.m_rd); end
            checks++; if (if4.inst_ready !== (k == 5)) begin errors++; $display("FAIL lat4_fetch_ready k=%0d got=%b", k, if4.inst_ready); end
            if (k == 2) begin
                checks++; if (if1.inst !== 32'h0050_0093) begin errors++; $display("FAIL lat1_fetch_inst got=%h exp=00500093", if1.inst); end
                if1.inst_req = 0;
            end
            if (k == 5) begin
                checks++; if (if4.inst !== 32'h0050_0093) begin errors++; $display("FAIL lat4_fetch_inst got=%h exp=00500093", if4.inst); end
                if4.inst_req = 0;
            end
        end
        do_reset();
        if1.inst_req = 1; if1.inst_adr = 32'h10; if1.mem_read = 1; if1.data_adr = 32'h40;
        if4.inst_req = 1; if4.inst_adr = 32'h10; if4.mem_read = 1; if4.data_adr = 32'h40;
        for (int k = 1; k <= 12; k++) begin
            tick();
            checks++; if (if1.m_rd !== (k == 1 || k == 4)) begin errors++; $display("FAIL lat1_cont_rd k=%0d got=%b", k, if1.m_rd); end
            checks++; if ({if1.data_ready, if1.inst_ready} !== {k == 2, k == 5}) begin errors++; $display("FAIL lat1_cont_ready k=%0d got=%b", k, {if1.data_ready, if1.inst_ready}); end
            checks++; if (if4.m_rd !== ((k >= 1 && k <= 4) || (k >= 7 && k <= 10))) begin errors++; $display("FAIL lat4_cont_rd k=%0d got=%b", k, if4.m_rd); end
            checks++; if ({if4.data_ready, if4.inst_ready} !== {k == 5, k == 11}) begin errors++; $display("FAIL lat4_cont_ready k=%0d got=%b", k, {if4.data_ready, if4.inst_ready}); end
            if (k == 2) begin
                checks++; if (if1.data_in !== 32'h1111_2222) begin errors++; $display("FAIL lat1_cont_data got=%h exp=11112222", if1.data_in); end
                if1.mem_read = 0;
            end
            if (k == 5) begin
                checks++; if (if1.inst !== 32'h0050_0093) begin errors++; $display("FAIL lat1_cont_inst got=%h exp=00500093", if1.inst); end
                checks++; if (if4.data_in !== 32'h1111_2222) begin errors++; $display("FAIL lat4_cont_data got=%h exp=11112222", if4.data_in); end
                if1.inst_req = 0; if4.mem_read = 0;
            end
            if (k == 11) begin
                checks++; if (if4.inst !== 32'h0050_0093) begin errors++; $display("FAIL lat4_cont_inst got=%h exp=00500093", if4.inst); end
                if4.inst_req = 0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_contention();
        test_alternation();
        test_write();
        test_drop();
        test_reset_mid();
        test_latency();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that lets the `riscv_pipeline` instruction-fetch port and data port share one single-ported, fixed-latency memory. It sits between the CPU's `inst_adr`/`inst` and `data_adr`/`data_in`/`data_out`/`mem_read`/`mem_write` ports and a unified memory. It sequences each access over `LATENCY` cycles, captures read data, and returns a one-cycle ready pulse per requester. Contention is resolved by data-first priority with alternation so neither port starves.

## Interface
- `LATENCY`, 2: cycles the memory command must be held; legal range 1..15.
- `clk` in 1: clock, all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `inst_req` in 1: fetch request, held until `inst_ready`.
- `inst_adr` in 32: fetch address, stable while `inst_req` is high.
- `inst` out 32: last fetched word, held until the next fetch completes.
- `inst_ready` out 1: one-cycle pulse, fetch complete.
- `mem_read` in 1: data read request.
- `mem_write` in 1: data write request; wins if both are high.
- `data_adr` in 32: data address.
- `data_out` in 32: write data from the CPU.
- `data_in` out 32: last data read word, held until the next data read completes.
- `data_ready` out 1: one-cycle pulse, data access complete.
- `m_adr` out 32: memory address.
- `m_wdata` out 32: memory write data.
- `m_rd` out 1: memory read strobe.
- `m_wr` out 1: memory write strobe.
- `m_rdata` in 32: memory read data, valid on the last cycle of an access.

## Operation
- States: IDLE, ACC_D, ACC_I, DONE. `last` is a 1-bit register holding the last grant (D or I); 4-bit `cnt` counts access cycles.
- IDLE:
  - Request inputs are sampled here.
  - Only `data_req = mem_read|mem_write` high → ACC_D.
  - Only `inst_req` high → ACC_I.
  - Both high → ACC_I if `last`==D, otherwise ACC_D.
  - Neither high → stay in IDLE.
  - On a grant: latch address, write data and op into command registers; load `cnt`=LATENCY-1; update `last`.
- ACC_D / ACC_I:
  - `m_adr`, `m_wdata`, `m_rd`, `m_wr` are driven from the command registers, constant for exactly LATENCY cycles.
  - ACC_I always reads.
  - `cnt` decrements each cycle.
  - On the cycle `cnt`==0:
    - capture `m_rdata` into `inst` (ACC_I) or into `data_in` (ACC_D read only; a write leaves `data_in` unchanged);
    - next state is DONE.
- DONE:
  - The matching ready output is high for this single cycle.
  - All `m_*` strobes are low.
  - Requests are ignored in DONE, so a requester's stale request is never regranted.
  - Next state is IDLE.
- Request dropped mid-access: the access still runs to completion and the ready pulse is still issued. Memory accesses are not abortable.
- `m_adr` and `m_wdata` hold their last values when idle; only the strobes are forced low.

## Timing
- Reset values: state=IDLE, `last`=I, `cnt`=0, `inst`=0, `data_in`=0, `inst_ready`=0, `data_ready`=0, `m_rd`=0, `m_wr`=0, `m_adr`=0, `m_wdata`=0.
- Reset mid-access: strobes are low in the cycle after the reset edge; no ready pulse is issued; captured data registers return to 0.
- Uncontended access:
  - request seen in IDLE at cycle t;
  - strobes high in cycles t+1..t+LATENCY;
  - ready high in cycle t+LATENCY+1;
  - IDLE again at t+LATENCY+2.
  - Throughput is one access per LATENCY+2 cycles.
- Captured data is visible on `inst`/`data_in` in the same cycle that ready is high.
- Ready outputs are registered, never combinational from inputs. `inst_ready` and `data_ready` are never high together.
- `m_rd` and `m_wr` are never high together.

## Test plan
- Reset, then `inst_req`=1 with `inst_adr`=0x10 and memory word 0x00500093 → `m_rd` high in cycles 1-2, `inst_ready` high in cycle 3, `inst`=0x00500093; `m_wr` stays 0 throughout.
- Contention from reset (`last`=I): `inst_req` and `mem_read` both high from cycle 0 → data granted first, then the fetch; `data_ready` pulses at cycle 3 and `inst_ready` at cycle 7.
- Alternation: both requesters held high continuously → grants alternate D,I,D,I; no two consecutive grants to the same port while the other is waiting.
- Write with `mem_write`=1 and `mem_read`=1 at `data_adr`=0x20, `data_out`=0xDEADBEEF → write performed with `m_wr` high for LATENCY cycles; `data_in` unchanged; a subsequent read of 0x20 returns 0xDEADBEEF.
- Request dropped after one access cycle → access still completes and ready still pulses exactly once; the arbiter then returns to IDLE with no regrant.
- `rst` asserted during ACC_D → next cycle state is IDLE, strobes low, no `data_ready` pulse; normal operation resumes after release.
- Repeat the first two scenarios with `LATENCY`=1 and `LATENCY`=4; the ready pulse lands at cycle LATENCY+1 after the request is seen.
